// File: rtl/tick_phase_seq.sv
// rtl/tick_phase_seq.sv - phase table sequencer for a free-running tick divider
module tick_phase_seq #(
  parameter int SLOT_AW        = 2,
  parameter int CNT_W          = 8,
  parameter int SETTLE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [SLOT_AW-1:0] cfg_addr,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [SLOT_AW-1:0] num_phases,
  input  logic               loop_en,
  input  logic               start,
  input  logic               abort,
  input  logic               div_stable,
  input  logic               div_tick,
  output logic               div_enable,
  output logic [CNT_W-1:0]   div_max_cnt,
  output logic               busy,
  output logic [SLOT_AW-1:0] phase_idx,
  output logic               phase_done,
  output logic               done,
  output logic               err
);

  localparam int SLOTS = 1 << SLOT_AW;
  localparam int TO_W  = $clog2(SETTLE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SETTLE_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   period_tab [SLOTS];
  logic [CNT_W-1:0]   count_tab  [SLOTS];
  logic [SLOT_AW-1:0] last_q, last_nx;
  logic               loop_q, loop_nx;
  logic [CNT_W-1:0]   tick_cnt, tick_cnt_nx;
  logic [TO_W-1:0]    to_cnt, to_cnt_nx;
  logic [SLOT_AW-1:0] phase_idx_nx;
  logic               div_enable_nx;
  logic [CNT_W-1:0]   div_max_cnt_nx;
  logic               phase_done_nx, done_nx, err_nx;
  logic               count_tick;
  logic [CNT_W-1:0]   tick_inc;

  // Phase table: only writable while idle; zero period/count are stored as 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        period_tab[i] <= CNT_W'(1);
        count_tab[i]  <= CNT_W'(1);
      end
    end else if (cfg_we && state == S_IDLE) begin
      period_tab[cfg_addr] <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
      count_tab[cfg_addr]  <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
    end
  end

  // Next-state and next-output decode; abort overrides everything at the end
  always_comb begin
    state_nx       = state;
    last_nx        = last_q;
    loop_nx        = loop_q;
    tick_cnt_nx    = tick_cnt;
    to_cnt_nx      = to_cnt;
    phase_idx_nx   = phase_idx;
    div_enable_nx  = div_enable;
    div_max_cnt_nx = div_max_cnt;
    phase_done_nx  = 1'b0;
    done_nx        = 1'b0;
    err_nx         = 1'b0;
    count_tick     = 1'b0;
    tick_inc       = tick_cnt + CNT_W'(1);

    case (state)
      S_IDLE: begin
        div_enable_nx = 1'b0;
        if (start) begin
          state_nx     = S_LOAD;
          phase_idx_nx = '0;
          last_nx      = num_phases;
          loop_nx      = loop_en;
        end
      end
      S_LOAD: begin
        div_max_cnt_nx = period_tab[phase_idx];
        div_enable_nx  = 1'b1;
        tick_cnt_nx    = '0;
        to_cnt_nx      = '0;
        state_nx       = S_SETTLE;
      end
      S_SETTLE: begin
        if (div_stable) begin
          state_nx   = S_RUN;
          count_tick = div_tick;
        end else if (to_cnt == TO_LAST) begin
          err_nx        = 1'b1;
          div_enable_nx = 1'b0;
          state_nx      = S_IDLE;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      S_RUN: begin
        if (!div_stable) begin
          state_nx  = S_SETTLE;
          to_cnt_nx = '0;
        end else begin
          count_tick = div_tick;
        end
      end
      S_DONE: begin
        done_nx       = 1'b1;
        div_enable_nx = 1'b0;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // A counted tick either advances the phase or just bumps the counter
    if (count_tick) begin
      tick_cnt_nx = tick_inc;
      if (tick_inc == count_tab[phase_idx]) begin
        phase_done_nx = 1'b1;
        if (phase_idx < last_q) begin
          phase_idx_nx = phase_idx + SLOT_AW'(1);
          state_nx     = S_LOAD;
        end else if (loop_q) begin
          phase_idx_nx = '0;
          state_nx     = S_LOAD;
        end else begin
          state_nx = S_DONE;
        end
      end
    end

    if (abort) begin
      state_nx      = S_IDLE;
      div_enable_nx = 1'b0;
      phase_idx_nx  = phase_idx;
      phase_done_nx = 1'b0;
      done_nx       = 1'b0;
      err_nx        = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last_q      <= '0;
      loop_q      <= 1'b0;
      tick_cnt    <= '0;
      to_cnt      <= '0;
      phase_idx   <= '0;
      div_enable  <= 1'b0;
      div_max_cnt <= '0;
      busy        <= 1'b0;
      phase_done  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      last_q      <= last_nx;
      loop_q      <= loop_nx;
      tick_cnt    <= tick_cnt_nx;
      to_cnt      <= to_cnt_nx;
      phase_idx   <= phase_idx_nx;
      div_enable  <= div_enable_nx;
      div_max_cnt <= div_max_cnt_nx;
      busy        <= (state_nx != S_IDLE);
      phase_done  <= phase_done_nx;
      done        <= done_nx;
      err         <= err_nx;
    end
  end

endmodule

// File: tb/tb_tick_phase_seq.sv
// tb/tb_tick_phase_seq.sv - self-checking bench for tick_phase_seq
module tb_tick_phase_seq;

  localparam int SLOT_AW = 2;
  localparam int CNT_W   = 8;

  logic               clk;
  logic               reset;
  logic               cfg_we;
  logic [SLOT_AW-1:0] cfg_addr;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_count;
  logic [SLOT_AW-1:0] num_phases;
  logic               loop_en;
  logic               start;
  logic               abort;
  logic               div_stable;
  logic               div_tick;
  logic               div_enable;
  logic [CNT_W-1:0]   div_max_cnt;
  logic               busy;
  logic [SLOT_AW-1:0] phase_idx;
  logic               phase_done;
  logic               done;
  logic               err;

  int checks = 0;
  int errors = 0;

  // Reference copy of the phase table, holding effective (nonzero) values
  int per_m [4];
  int cnt_m [4];

  tick_phase_seq dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_period  (cfg_period),
    .cfg_count   (cfg_count),
    .num_phases  (num_phases),
    .loop_en     (loop_en),
    .start       (start),
    .abort       (abort),
    .div_stable  (div_stable),
    .div_tick    (div_tick),
    .div_enable  (div_enable),
    .div_max_cnt (div_max_cnt),
    .busy        (busy),
    .phase_idx   (phase_idx),
    .phase_done  (phase_done),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   32'(div_enable), 0);
    chk({tag, "_max"},  32'(div_max_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_idx"},  32'(phase_idx), 0);
    chk({tag, "_pd"},   32'(phase_done), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"},  32'(err), 0);
  endtask

  task automatic write_slot(input int a, input int p, input int c);
    cfg_we = 1'b1; cfg_addr = SLOT_AW'(a);
    cfg_period = CNT_W'(p); cfg_count = CNT_W'(c);
    step();
    cfg_we = 1'b0;
    per_m[a] = (p == 0) ? 1 : p;
    cnt_m[a] = (c == 0) ? 1 : c;
  endtask

  // Runs one sequence with random divider behaviour. The reference works in
  // terms of phases: each phase needs count ticks seen while the divider is
  // stable; the cycle after start and each phase boundary is a reload gap in
  // which ticks are not counted; after the last phase one more cycle ends it.
  task automatic run_seq(input int num, input bit lp, input int abort_after,
                         output int n_pd, output int n_done);
    int idx, ticks, lows;
    bit gap, loaded, fin, fin_pend, s, t, ab, pd_e, done_e;
    int max_e;
    n_pd = 0; n_done = 0;
    num_phases = SLOT_AW'(num); loop_en = lp; start = 1'b1;
    step();
    start = 1'b0;
    num_phases = SLOT_AW'($urandom_range(0, 3)); loop_en = $urandom_range(0, 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_en",   32'(div_enable), 0);
    chk("start_idx",  32'(phase_idx), 0);
    gap = 1; loaded = 0; fin = 0; fin_pend = 0; idx = 0; ticks = 0; lows = 0; max_e = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      s = (lows >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      lows = s ? 0 : lows + 1;
      t = $urandom_range(0, 1);
      ab = (abort_after > 0 && cyc == abort_after);
      if (ab) begin s = 1; t = 1; end
      div_stable = s; div_tick = t; abort = ab;
      start = $urandom_range(0, 1);
      cfg_we = 1'b1; cfg_addr = SLOT_AW'($urandom_range(0, 3));
      cfg_period = CNT_W'($urandom_range(20, 99)); cfg_count = CNT_W'($urandom_range(20, 99));
      step();
      if (phase_done) n_pd++;
      if (done) n_done++;
      pd_e = 0; done_e = 0;
      if (ab) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_en",   32'(div_enable), 0);
        chk("abort_pd",   32'(phase_done), 0);
        chk("abort_done", 32'(done), 0);
        fin = 1;
      end else begin
        if (fin_pend) begin
          done_e = 1; fin = 1;
        end else if (gap) begin
          gap = 0; loaded = 1; max_e = per_m[idx];
        end else if (s && t) begin
          ticks++;
          if (ticks == cnt_m[idx]) begin
            pd_e = 1; ticks = 0;
            if (idx < num) begin idx++; gap = 1; end
            else if (lp) begin idx = 0; gap = 1; end
            else fin_pend = 1;
          end
        end
        chk("run_pd",   32'(phase_done), 32'(pd_e));
        chk("run_done", 32'(done), 32'(done_e));
        chk("run_busy", 32'(busy), 32'(!fin));
        chk("run_en",   32'(div_enable), 32'(loaded && !fin));
        chk("run_idx",  32'(phase_idx), 32'(idx));
        chk("run_err",  32'(err), 0);
        if (loaded) chk("run_max", 32'(div_max_cnt), 32'(max_e));
      end
    end
    chk("run_finished", 32'(fin), 1);
    cfg_we = 1'b0; abort = 1'b0; start = 1'b0; div_stable = 1'b0; div_tick = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int npd, ndn, nph;
    reset = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_period = 0; cfg_count = 0;
    num_phases = 0; loop_en = 0; start = 0; abort = 0; div_stable = 0; div_tick = 0;
    for (int i = 0; i < 4; i++) begin per_m[i] = 1; cnt_m[i] = 1; end
    #2 reset = 1'b0;
    #4 chk_all_zero("reset");
    #6 reset = 1'b1;
    step();

    // Two-phase sequence: periods 3 then 5
    write_slot(0, 3, 2);
    write_slot(1, 5, 1);
    run_seq(1, 0, 0, npd, ndn);
    chk("two_phase_pd_count", 32'(npd), 2);
    chk("two_phase_done_count", 32'(ndn), 1);
    chk("two_phase_en_after", 32'(div_enable), 0);

    // Zero config stored as 1
    write_slot(0, 0, 0);
    run_seq(0, 0, 0, npd, ndn);
    chk("zero_cfg_pd_count", 32'(npd), 1);
    chk("zero_cfg_done_count", 32'(ndn), 1);

    // Looping single phase, then abort
    write_slot(0, 2, 2);
    run_seq(0, 1, 40, npd, ndn);
    chk("loop_no_done", 32'(ndn), 0);
    chk("loop_some_pd", 32'(npd > 0), 1);

    // Abort wins over start in idle
    abort = 1; start = 1;
    step();
    chk("abort_vs_start_busy", 32'(busy), 0);
    abort = 0; start = 0;
    step();

    // Settle timeout
    write_slot(0, 2, 1);
    num_phases = 0; loop_en = 0; div_stable = 0; start = 1;
    step();
    start = 0;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("timeout_err_early", 32'(err), 0);
    end
    step();
    chk("timeout_err", 32'(err), 1);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_en", 32'(div_enable), 0);
    step();
    chk("timeout_err_pulse", 32'(err), 0);

    // Stable drop in RUN after 1 of 3 ticks
    write_slot(0, 4, 3);
    start = 1;
    step();
    start = 0; div_stable = 1; div_tick = 0;
    step();
    step();
    div_tick = 1;
    step();
    div_stable = 0;
    for (int k = 0; k < 3; k++) step();
    chk("drop_still_busy", 32'(busy), 1);
    div_stable = 1;
    step();
    chk("drop_pd_after_2", 32'(phase_done), 0);
    step();
    chk("drop_pd_after_3", 32'(phase_done), 1);
    div_tick = 0;
    step();
    chk("drop_done", 32'(done), 1);
    div_stable = 0;
    step();

    // Random tables and lengths
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 4; a++) write_slot(a, $urandom_range(0, 7), $urandom_range(0, 3));
      nph = $urandom_range(0, 3);
      run_seq(nph, 0, 0, npd, ndn);
      chk("rand_pd_count", 32'(npd), 32'(nph + 1));
      chk("rand_done_count", 32'(ndn), 1);
    end

    // Asynchronous reset mid-RUN; table returns to period=1, count=1
    write_slot(0, 6, 5);
    num_phases = 0; start = 1;
    step();
    start = 0; div_stable = 1; div_tick = 0;
    step();
    step();
    div_tick = 1;
    step();
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    div_stable = 0; div_tick = 0;
    step();
    chk_all_zero("async_reset_held");
    #2 reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin per_m[i] = 1; cnt_m[i] = 1; end
    run_seq(3, 0, 0, npd, ndn);
    chk("post_reset_pd_count", 32'(npd), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
